// File: rtl/sha_output_pkg.sv
// -----------------------------------------------------------------------------
// sha_output_pkg
// Shared definitions for the SHA output path: the data word width and the
// state encoding used by the parallel-to-serial frame transmitter.
// -----------------------------------------------------------------------------
package sha_output_pkg;

    localparam int WORD_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

endpackage : sha_output_pkg

// File: rtl/pts_sr_tx.sv
// -----------------------------------------------------------------------------
// pts_sr_tx
// Parallel-to-serial frame transmitter. Captures NUM_WORDS words in one cycle
// and streams them out over a valid/ready handshake, highest index first.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   n_rst        : asynchronous active-low reset
//   clear        : synchronous abort of any frame in progress (beats load/transfer)
//   load         : capture parallel_in when load_ready is high
//   parallel_in  : NUM_WORDS x WORD_W words; index NUM_WORDS-1 is sent first
//   load_ready   : high while idle, a load is accepted this cycle
//   serial_out   : word currently offered (0 while idle)
//   serial_valid : serial_out is valid
//   serial_ready : downstream accepts serial_out this cycle
//   serial_last  : serial_out is the final word of the frame
//   done         : one-cycle pulse after the final word transfers
// -----------------------------------------------------------------------------
module pts_sr_tx
    import sha_output_pkg::*;
#(
    parameter int NUM_WORDS = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              load,
    input  logic [WORD_W-1:0] parallel_in [NUM_WORDS],
    output logic              load_ready,
    output logic [WORD_W-1:0] serial_out,
    output logic              serial_valid,
    input  logic              serial_ready,
    output logic              serial_last,
    output logic              done
);

    localparam int               CNT_W    = $clog2(NUM_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] buf_q [NUM_WORDS];
    logic [WORD_W-1:0] buf_d [NUM_WORDS];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;

    // NOTE: every signal gets its hold value before any branch, so no path
    // through this block leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        if (clear) begin
            state_d = IDLE;
            buf_d   = '{default: '0};
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        buf_d   = parallel_in;
                        cnt_d   = '0;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    if (serial_ready) begin
                        // Shift toward the output end; zeros enter at index 0.
                        for (int i = NUM_WORDS - 1; i > 0; i--) begin
                            buf_d[i] = buf_q[i-1];
                        end
                        buf_d[0] = '0;
                        if (cnt_q == LAST_IDX) begin
                            // Final word: the counter restarts instead of wrapping.
                            state_d = IDLE;
                            cnt_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // NOTE: the word buffer is reset along with the control state because the
    // block must present all-zero contents immediately after reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            buf_q   <= '{default: '0};
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign load_ready   = (state_q == IDLE);
    assign serial_valid = (state_q == SEND);
    assign serial_out   = (state_q == SEND) ? buf_q[NUM_WORDS-1] : '0;
    assign serial_last  = (state_q == SEND) && (cnt_q == LAST_IDX);
    assign done         = done_q;

endmodule : pts_sr_tx

// File: doc/pts_sr_tx.md
PTS_SR_TX -- requirements
Module: pts_sr_tx

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 8, meaning the number of 32-bit words per frame (legal range 2..256).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port n_rst  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port clear  input  1  synchronous abort of any frame in progress.
REQ-005 SHALL have port load  input  1  request to capture parallel_in.
REQ-006 SHALL have port parallel_in  input  32 x NUM_WORDS  unpacked array of words; index NUM_WORDS-1 is sent first.
REQ-007 SHALL have port load_ready  output  1  block can accept a load this cycle.
REQ-008 SHALL have port serial_out  output  32  current word offered.
REQ-009 SHALL have port serial_valid  output  1  serial_out is valid.
REQ-010 SHALL have port serial_ready  input  1  downstream accepts serial_out.
REQ-011 SHALL have port serial_last  output  1  serial_out is the final word of the frame.
REQ-012 SHALL have port done  output  1  one-cycle pulse after the final word transfers.

Function
REQ-013 SHALL implement a two-state FSM, IDLE and SEND.
REQ-014 SHALL drive load_ready=1 in IDLE and 0 in SEND.
REQ-015 SHALL, when IDLE and load=1 and clear=0, copy all of parallel_in into an internal word buffer, clear the word counter, and enter SEND on the next edge.
REQ-016 SHALL ignore load while in SEND; the buffer is not modified.
REQ-017 SHALL drive serial_valid=1 in SEND and 0 in IDLE.
REQ-018 SHALL drive serial_out combinationally from buffer[NUM_WORDS-1], and SHALL force serial_out to 0 in IDLE.
REQ-019 SHALL complete a transfer on a rising edge where serial_valid=1 and serial_ready=1.
REQ-020 SHALL, on each transfer, shift the buffer so that buffer[i] takes buffer[i-1] for i=1..NUM_WORDS-1, load buffer[0] with 0, and increment the counter.
REQ-021 SHALL hold serial_out, the buffer and the counter stable while serial_valid=1 and serial_ready=0, with no limit on the stall length.
REQ-022 SHALL size the counter as $clog2(NUM_WORDS) bits; the counter SHALL NOT wrap inside a frame.
REQ-023 SHALL drive serial_last=1 exactly when in SEND and counter==NUM_WORDS-1.
REQ-024 SHALL, on the transfer where serial_last=1, return to IDLE and assert done for exactly the following cycle.
REQ-025 SHALL make frame latency 1 cycle from the load edge to serial_valid, and SHALL send NUM_WORDS words in NUM_WORDS cycles when serial_ready is held high.
REQ-026 SHALL permit a new load in the same cycle that done is high (back-to-back frames, one idle cycle between them).
REQ-027 SHALL give clear priority over load and over a transfer: next state IDLE, buffer zeroed, counter zeroed, no done pulse.
REQ-028 SHALL produce a word order such that a serial-to-parallel shift register of the same NUM_WORDS, shifting on each transfer, ends holding an array identical to the captured parallel_in.

Reset
REQ-029 SHALL, when n_rst=0, immediately force: state IDLE, buffer all 0, counter 0, done 0, and therefore serial_valid 0, serial_last 0, serial_out 0, load_ready 1.
REQ-030 SHALL, on reset asserted mid-frame, discard the frame without a done pulse.

Structure
REQ-031 SHALL take the FSM state enum (IDLE, SEND) and the constant WORD_W=32 from the shared package sha_output_pkg.
REQ-032 SHALL be a single module with the buffer and counter inline; no sub-module.

Verification
REQ-033 Basic frame: NUM_WORDS=8, load with parallel_in[i]=32'h1000_0000+i, serial_ready=1 -> serial_out 0x10000007 down to 0x10000000 on consecutive cycles; serial_last on the 8th word; done on the next cycle.
REQ-034 Backpressure: same frame, serial_ready low for 3 cycles at word 3 -> serial_out holds 0x10000004 throughout the stall; total 11 cycles; no word lost or duplicated.
REQ-035 Load during SEND: assert load with different data at word 2 -> ignored; the original frame completes unchanged.
REQ-036 Clear mid-frame: clear at word 5 -> next cycle serial_valid=0 and load_ready=1; no done pulse; a subsequent load sends a full clean frame.
REQ-037 Async reset mid-frame: n_rst low between edges -> outputs reach reset values without a clock edge; on release the block is IDLE.
REQ-038 Loopback: output feeds a serial-to-parallel shift register (NUM_WORDS=8, shift on transfer), 100 random frames with random serial_ready -> captured array equals parallel_in each frame, and back-to-back loads are accepted on done.
